id_ex_stage: RTL and testbench

Decode-to-execute pipeline register and operand issue logic for the five-stage core. It captures one decoded instruction per cycle and produces the execute-stage ALU operands (`alu_in_a`, `alu_in_b`) and the 3-bit ALU `control` code. It also provides forwarding from EX/MEM and MEM/WB, load-use hazard detection with bubble insertion, and stall/flush handling. It sits directly upstream of the ALU, whose operand and control inputs it drives.

---
 rtl/id_ex_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register and ALU operand issue.
//
// Captures one decoded instruction per cycle. It then presents the held
// instruction to the execute stage:
//   - alu_in_a / alu_in_b: ALU operands, with EX/MEM and MEM/WB forwarding
//   - control: 3-bit ALU code
//   - ex_*: registered side-effect flags and fields
// It also detects load-use hazards. A load-use hazard holds decode and
// turns the next EX slot into a bubble.
//
// Ports:
//   clock, reset       rising-edge clock; synchronous active-low reset
//   stall, flush       hold all state / squash the held instruction
//   dec_*              decoded instruction from the ID stage
//   exm_*, mwb_*       forwarding sources (EX/MEM, MEM/WB)
//   load_use_stall     combinational: decode must hold this cycle
//   alu_in_a/b         combinational operands
//   ex_store_data      combinational forwarded rs2
//   control, ex_*      registered execute-stage control
module id_ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        dec_valid,
    input  logic [31:0] dec_pc,
    input  logic [31:0] dec_rs1_data,
    input  logic [31:0] dec_rs2_data,
    input  logic [31:0] dec_imm,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic [6:0]  dec_opcode,
    input  logic [2:0]  dec_funct3,
    input  logic        dec_funct7_5,
    input  logic        exm_reg_write,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_result,
    input  logic        mwb_reg_write,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_result,
    output logic        load_use_stall,
    output logic [31:0] alu_in_a,
    output logic [31:0] alu_in_b,
    output logic [2:0]  control,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_is_branch,
    output logic        ex_is_jump,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_store_data
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Operand selects. The all-zero encoding picks rs1/rs2, so a cleared
    // (bubble) state yields operands from index 0 with data 0, which
    // evaluates to 0 because x0 is never forwarded.
    localparam logic [1:0] SEL_A_RS1  = 2'd0;
    localparam logic [1:0] SEL_A_ZERO = 2'd1;
    localparam logic [1:0] SEL_A_PC   = 2'd2;
    localparam logic [1:0] SEL_B_RS2  = 2'd0;
    localparam logic [1:0] SEL_B_IMM  = 2'd1;
    localparam logic [1:0] SEL_B_FOUR = 2'd2;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
        logic        is_jump;
        logic [2:0]  control;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
    } ex_state_t;

    ex_state_t   ex_q, ex_d, cap;
    logic [31:0] fwd_rs1, fwd_rs2;
    logic        reads_rs2;

    // SLT/SLTU both map to subtract; ex_funct3 distinguishes them later.
    function automatic logic [2:0] alu_ctrl(input logic [2:0] f3, input logic f7_5,
                                            input logic is_r);
        case (f3)
            3'b000:         alu_ctrl = (is_r && f7_5) ? 3'b010 : 3'b000;
            3'b010, 3'b011: alu_ctrl = 3'b010;
            default:        alu_ctrl = f3;
        endcase
    endfunction

    function automatic logic [31:0] forward(input logic [4:0] idx, input logic [31:0] rf_val,
                                            input logic ew, input logic [4:0] erd,
                                            input logic [31:0] eres, input logic mw,
                                            input logic [4:0] mrd, input logic [31:0] mres);
        if (ew && erd != 5'd0 && erd == idx)      forward = eres;
        else if (mw && mrd != 5'd0 && mrd == idx) forward = mres;
        else                                      forward = rf_val;
    endfunction

    // Decode of the incoming instruction into its held form.
    always_comb begin
        cap          = '0;
        cap.valid    = 1'b1;
        cap.rd       = dec_rd;
        cap.funct3   = dec_funct3;
        cap.pc       = dec_pc;
        cap.imm      = dec_imm;
        cap.rs1      = dec_rs1;
        cap.rs2      = dec_rs2;
        cap.rs1_data = dec_rs1_data;
        cap.rs2_data = dec_rs2_data;
        cap.sel_a    = SEL_A_RS1;
        cap.sel_b    = SEL_B_RS2;
        case (dec_opcode)
            OP_R: begin
                cap.reg_write = 1'b1;
                cap.control   = alu_ctrl(dec_funct3, dec_funct7_5, 1'b1);
            end
            OP_IMM: begin
                cap.reg_write = 1'b1;
                cap.sel_b     = SEL_B_IMM;
                cap.control   = alu_ctrl(dec_funct3, dec_funct7_5, 1'b0);
            end
            OP_LOAD: begin
                cap.reg_write = 1'b1;
                cap.mem_read  = 1'b1;
                cap.sel_b     = SEL_B_IMM;
            end
            OP_STORE: begin
                cap.mem_write = 1'b1;
                cap.sel_b     = SEL_B_IMM;
            end
            OP_BRANCH: begin
                cap.is_branch = 1'b1;
                cap.control   = 3'b010;
            end
            OP_LUI: begin
                cap.reg_write = 1'b1;
                cap.sel_a     = SEL_A_ZERO;
                cap.sel_b     = SEL_B_IMM;
            end
            OP_AUIPC: begin
                cap.reg_write = 1'b1;
                cap.sel_a     = SEL_A_PC;
                cap.sel_b     = SEL_B_IMM;
            end
            OP_JAL, OP_JALR: begin
                cap.reg_write = 1'b1;
                cap.is_jump   = 1'b1;
                cap.sel_a     = SEL_A_PC;
                cap.sel_b     = SEL_B_FOUR;
            end
            default: ;
        endcase
    end

    // rs2 only matters for the hazard when the instruction actually reads it.
    assign reads_rs2 = (dec_opcode == OP_R) || (dec_opcode == OP_STORE) ||
                       (dec_opcode == OP_BRANCH);

    assign load_use_stall = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) && dec_valid &&
                            ((ex_q.rd == dec_rs1) || ((ex_q.rd == dec_rs2) && reads_rs2));

    // flush beats stall, stall beats the load-use bubble.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            if (load_use_stall || !dec_valid) ex_d = '0;
            else                              ex_d = cap;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign fwd_rs1 = forward(ex_q.rs1, ex_q.rs1_data, exm_reg_write, exm_rd, exm_result,
                             mwb_reg_write, mwb_rd, mwb_result);
    assign fwd_rs2 = forward(ex_q.rs2, ex_q.rs2_data, exm_reg_write, exm_rd, exm_result,
                             mwb_reg_write, mwb_rd, mwb_result);

    always_comb begin
        case (ex_q.sel_a)
            SEL_A_ZERO: alu_in_a = 32'd0;
            SEL_A_PC:   alu_in_a = ex_q.pc;
            default:    alu_in_a = fwd_rs1;
        endcase
        case (ex_q.sel_b)
            SEL_B_IMM:  alu_in_b = ex_q.imm;
            SEL_B_FOUR: alu_in_b = 32'd4;
            default:    alu_in_b = fwd_rs2;
        endcase
    end

    assign ex_store_data = fwd_rs2;
    assign control       = ex_q.control;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_is_branch  = ex_q.is_branch;
    assign ex_is_jump    = ex_q.is_jump;
    assign ex_rd         = ex_q.rd;
    assign ex_funct3     = ex_q.funct3;
    assign ex_pc         = ex_q.pc;
    assign ex_imm        = ex_q.imm;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage. The driver changes inputs on the falling
// edge and pushes the outputs expected for that cycle. The monitor samples
// 3 time units later, pops each entry and compares.
module tb_id_ex_stage;
    logic        clock = 1'b0;
    logic        reset, stall, flush, dec_valid, dec_funct7_5;
    logic [31:0] dec_pc, dec_rs1_data, dec_rs2_data, dec_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic        load_use_stall;
    logic [31:0] alu_in_a, alu_in_b, ex_pc, ex_imm, ex_store_data;
    logic [2:0]  control, ex_funct3;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch, ex_is_jump;
    logic [4:0]  ex_rd;

    id_ex_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_rs1_data(dec_rs1_data),
        .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm), .dec_rs1(dec_rs1),
        .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_opcode(dec_opcode),
        .dec_funct3(dec_funct3), .dec_funct7_5(dec_funct7_5),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .load_use_stall(load_use_stall), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
        .control(control), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_store_data(ex_store_data)
    );

    always #5 clock = ~clock;

    // flag vector order: {valid, reg_write, mem_read, mem_write, is_branch, is_jump}
    localparam logic [5:0] FV = 6'b100000, FRW = 6'b010000, FMR = 6'b001000;
    localparam logic [5:0] FMW = 6'b000100, FBR = 6'b000010, FJP = 6'b000001;

    typedef struct {
        bit          is_sd;
        bit          chk_ab;
        logic [5:0]  flags;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] a, b, sd;
        logic        lus;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic expect_ex(input string nm, input logic [5:0] fl, input logic [2:0] ctrl,
                             input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                             input logic lus, input bit cab = 1'b1);
        exp_t e;
        e = '{is_sd: 1'b0, chk_ab: cab, flags: fl, ctrl: ctrl, rd: rd, a: a, b: b,
              sd: 32'd0, lus: lus};
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    task automatic expect_sd(input string nm, input logic [31:0] sd);
        exp_t e;
        e = '{is_sd: 1'b1, chk_ab: 1'b0, flags: 6'd0, ctrl: 3'd0, rd: 5'd0, a: 32'd0,
              b: 32'd0, sd: sd, lus: 1'b0};
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    // Monitor: compares whatever the driver queued for this cycle.
    initial begin
        forever begin
            @(negedge clock);
            #3;
            while (sb.size() != 0) begin
                exp_t  e;
                string n;
                e = sb.pop_front();
                n = sb_name.pop_front();
                if (e.is_sd) begin
                    chk({n, ".store_data"}, ex_store_data, e.sd);
                end else begin
                    chk({n, ".flags"}, {26'd0, ex_valid, ex_reg_write, ex_mem_read,
                                        ex_mem_write, ex_is_branch, ex_is_jump},
                        {26'd0, e.flags});
                    chk({n, ".control"}, {29'd0, control}, {29'd0, e.ctrl});
                    chk({n, ".rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
                    chk({n, ".lus"}, {31'd0, load_use_stall}, {31'd0, e.lus});
                    if (e.chk_ab) begin
                        chk({n, ".a"}, alu_in_a, e.a);
                        chk({n, ".b"}, alu_in_b, e.b);
                    end
                end
            end
        end
    end

    task automatic nxt();
        @(negedge clock);
    endtask

    task automatic dec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [31:0] pc);
        dec_valid = 1'b1; dec_opcode = op; dec_funct3 = f3; dec_funct7_5 = f7;
        dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
        dec_rs1_data = d1; dec_rs2_data = d2; dec_imm = imm; dec_pc = pc;
    endtask

    task automatic fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                       input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        exm_reg_write = ew; exm_rd = erd; exm_result = eres;
        mwb_reg_write = mw; mwb_rd = mrd; mwb_result = mres;
    endtask

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111;

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        fwd(0, 0, 0, 0, 0, 0);
        dec(R, 3'b000, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'h0);  // ADD x3,x1,x2

        // Reset held two edges with a valid ADD on the decode inputs.
        nxt(); expect_ex("rst0", 6'd0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
        nxt(); expect_ex("rst1", 6'd0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        nxt(); expect_ex("add", FV|FRW, 3'b000, 5'd3, 32'd5, 32'd7, 1'b0);
        dec(R, 3'b000, 1, 5'd1, 5'd2, 5'd4, 32'd10, 32'd3, 32'd0, 32'h4);  // SUB
        nxt(); expect_ex("sub", FV|FRW, 3'b010, 5'd4, 32'd10, 32'd3, 1'b0);
        dec(I, 3'b101, 0, 5'd1, 5'd0, 5'd5, 32'h80, 32'd0, 32'd4, 32'h8);  // SRLI
        nxt(); expect_ex("srli", FV|FRW, 3'b101, 5'd5, 32'h80, 32'd4, 1'b0);
        dec(R, 3'b000, 0, 5'd5, 5'd2, 5'd6, 32'h99, 32'd1, 32'd0, 32'hc);  // ADD x6,x5,x2

        // Forwarding priority while the ADD is held by stall.
        nxt(); stall = 1'b1; dec_valid = 1'b0;
        fwd(1, 5'd5, 32'h11, 1, 5'd5, 32'h22);
        expect_ex("fwd_exm", FV|FRW, 3'b000, 5'd6, 32'h11, 32'd1, 1'b0);
        nxt(); exm_reg_write = 1'b0;
        expect_ex("fwd_mwb", FV|FRW, 3'b000, 5'd6, 32'h22, 32'd1, 1'b0);
        nxt(); exm_reg_write = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
        expect_ex("fwd_x0", FV|FRW, 3'b000, 5'd6, 32'h99, 32'd1, 1'b0);
        stall = 1'b0;
        dec(LUI, 3'b000, 0, 5'd5, 5'd0, 5'd10, 32'h5555, 32'd0, 32'h12345000, 32'h10);

        // LUI must ignore a forwarding match on its (unused) rs1 field.
        nxt(); exm_rd = 5'd5; exm_result = 32'h11;
        expect_ex("lui", FV|FRW, 3'b000, 5'd10, 32'd0, 32'h12345000, 1'b0);
        dec(ST, 3'b010, 0, 5'd1, 5'd9, 5'd0, 32'h300, 32'h55, 32'h10, 32'h14);  // SW x9,16(x1)
        nxt(); fwd(0, 5'd0, 32'd0, 1, 5'd9, 32'h77);
        expect_ex("sw", FV|FMW, 3'b000, 5'd0, 32'h300, 32'h10, 1'b0);
        expect_sd("sw", 32'h77);
        dec(LD, 3'b010, 0, 5'd1, 5'd0, 5'd7, 32'h200, 32'd0, 32'd8, 32'h18);  // LW x7,8(x1)

        // Load-use: one bubble, then the ADD picks the load data from MEM/WB.
        nxt(); mwb_reg_write = 1'b0;
        dec(R, 3'b000, 0, 5'd7, 5'd1, 5'd8, 32'd0, 32'd3, 32'd0, 32'h1c);  // ADD x8,x7,x1
        expect_ex("lw", FV|FRW|FMR, 3'b000, 5'd7, 32'h200, 32'd8, 1'b1);
        nxt(); expect_ex("lu_bub", 6'd0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
        nxt(); fwd(0, 5'd0, 32'd0, 1, 5'd7, 32'hABC);
        expect_ex("lu_fwd", FV|FRW, 3'b000, 5'd8, 32'hABC, 32'd3, 1'b0);
        dec(R, 3'b111, 0, 5'd1, 5'd2, 5'd9, 32'hF0, 32'h3C, 32'd0, 32'h40);  // AND

        // Stall for three edges, then stall+flush together.
        nxt(); mwb_reg_write = 1'b0;
        expect_ex("and", FV|FRW, 3'b111, 5'd9, 32'hF0, 32'h3C, 1'b0);
        stall = 1'b1;
        dec(R, 3'b110, 0, 5'd1, 5'd2, 5'd11, 32'd1, 32'd2, 32'd0, 32'h44);  // OR
        for (int k = 1; k <= 3; k++) begin
            nxt(); expect_ex($sformatf("stall%0d", k), FV|FRW, 3'b111, 5'd9, 32'hF0, 32'h3C, 1'b0);
        end
        flush = 1'b1;
        nxt(); expect_ex("flush", 6'd0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
        flush = 1'b0; stall = 1'b0;
        dec(JAL, 3'b000, 0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h20, 32'h100);

        // Jumps, AUIPC, branch, unknown opcode, invalid slot.
        nxt(); expect_ex("jal", FV|FRW|FJP, 3'b000, 5'd1, 32'h100, 32'd4, 1'b0);
        dec(AUIPC, 3'b000, 0, 5'd0, 5'd0, 5'd2, 32'd0, 32'd0, 32'h1000, 32'h200);
        nxt(); expect_ex("auipc", FV|FRW, 3'b000, 5'd2, 32'h200, 32'h1000, 1'b0);
        dec(BR, 3'b000, 0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd6, 32'h20, 32'h204);
        nxt(); expect_ex("beq", FV|FBR, 3'b010, 5'd0, 32'd5, 32'd6, 1'b0);
        dec(7'b1110011, 3'b000, 0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'd0, 32'h208);
        nxt(); expect_ex("unknown", FV, 3'b000, 5'd3, 32'd0, 32'd0, 1'b0, 1'b0);
        dec(R, 3'b000, 0, 5'd1, 5'd2, 5'd4, 32'd1, 32'd1, 32'd0, 32'h20c);
        nxt(); expect_ex("add2", FV|FRW, 3'b000, 5'd4, 32'd1, 32'd1, 1'b0);
        dec_valid = 1'b0;
        nxt(); expect_ex("invalid", 6'd0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
        dec(R, 3'b000, 0, 5'd1, 5'd2, 5'd5, 32'd2, 32'd3, 32'd0, 32'h210);

        // Reset wins over stall.
        nxt(); expect_ex("add3", FV|FRW, 3'b000, 5'd5, 32'd2, 32'd3, 1'b0);
        stall = 1'b1; reset = 1'b0;
        nxt(); expect_ex("rst_stall", 6'd0, 3'b000, 5'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1; stall = 1'b0; dec_valid = 1'b0;

        nxt(); nxt();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
